action_issue_ctrl: RTL
======================

# action_issue_ctrl

Issue scheduler between the lookup engine and the action engine of one pipeline stage. It buffers {action, PHV} pairs from the lookup engine in a small FIFO and issues them to the action engine. It tracks outstanding in-flight PHVs via the engine's output-valid strobe. It serialises stateful memory actions (load/store) against all other traffic, so no ALU PHV is in flight while a memory action executes and vice versa.

## Interface
- STAGE, 0: stage index, passed through for identification only.
- PHV_LEN, 1024+7+24*8+5*20+256: PHV width.
- ACTION_LEN, 25: action word width; opcode is action[ACTION_LEN-1 -: 4].
- FIFO_DEPTH, 4: input buffer entries, power of two.
- MAX_OUT, 4: maximum PHVs in flight inside the action engine.

Ports:
- axis_clk  in  1  clock; all logic on rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- action_in  in  ACTION_LEN  action word from lookup engine.
- action_in_valid  in  1  action_in/phv_in valid this cycle.
- phv_in  in  PHV_LEN  PHV from lookup engine.
- in_ready  out  1  = FIFO not full (combinational from count).
- action_out  out  ACTION_LEN  action to action engine (registered).
- action_out_valid  out  1  one-cycle issue strobe (registered).
- phv_out  out  PHV_LEN  PHV to action engine (registered).
- eng_done  in  1  action engine phv_out_valid; one pulse per completed PHV.
- outstanding  out  3  current in-flight count, 0..MAX_OUT.
- err_underflow  out  1  sticky; eng_done seen with outstanding==0.

## Operation
- Accept: write when action_in_valid && in_ready. When the FIFO is full, input is dropped; the upstream must honour in_ready. There is no bypass: an entry is written first and issued no earlier than the next edge.
- Memory class: opcode 4'b1000 (load) or 4'b1001 (store). Every other opcode, including add 0001, sub 0010, addi 0011, subi 0100, redirect and discard, is ALU class.
- FSM, evaluated each edge on the FIFO head:
  - IDLE: if the head is ALU class and outstanding<MAX_OUT (counting a same-cycle eng_done), pop and issue. If the head is memory class, issue only if the effective outstanding==0 and go to MEM_WAIT; otherwise go to DRAIN with no issue.
  - DRAIN: no issue. When the effective outstanding reaches 0, issue the memory head and go to MEM_WAIT.
  - MEM_WAIT: no issue. On the eng_done that brings the count to 0, go to IDLE. The next head may issue at the earliest on the following edge.
- Effective outstanding = outstanding − eng_done (this cycle).
- Counter rules:
  - Issue and done in the same cycle leave the count unchanged.
  - Issue alone adds 1; done alone subtracts 1.
  - Done at 0 keeps the count at 0 and sets err_underflow.
  - The count never exceeds MAX_OUT.
- Issue: action_out and phv_out load from the FIFO head, and action_out_valid=1 for exactly that cycle. When not issuing, action_out_valid=0 and the data registers hold their last value.
- FIFO: read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo the depth. Occupancy is log2(FIFO_DEPTH)+1 bits. Simultaneous push and pop leave occupancy unchanged.
- err_underflow clears only on reset.

## Timing
- Reset (aresetn=0, asynchronous), applied immediately:
  - action_out_valid=0, action_out=0, phv_out=0.
  - outstanding=0, err_underflow=0, FSM=IDLE, FIFO empty.
  - in_ready=1.
- A reset mid-operation discards the FIFO contents and in-flight accounting. eng_done pulses arriving after reset for pre-reset PHVs set err_underflow; that is intended.
- Minimum latency: accepted at edge k, empty FIFO, IDLE → action_out_valid high in the cycle after edge k+1.
- Throughput: ALU actions issue back-to-back, one per cycle, while outstanding<MAX_OUT.
- A memory action blocks issue from the cycle it reaches the head (if in-flight work exists) until one edge after its own eng_done.
- in_ready falls in the cycle after the write that fills the FIFO. It rises in the cycle after a pop that frees an entry.

## Test plan
- Reset, then one ALU pair: action_in={4'b0001,2'b00,3'd0,2'b00,3'd1,11'b0}, phv_in[PHV_LEN-1 -: 4]=4'b1111, valid for 1 cycle at edge k. Required: action_out_valid high for exactly the one cycle after edge k+1; action_out and phv_out equal the inputs; outstanding=1 until eng_done, then 0.
- Back-to-back ALU with eng_done held low: 6 addi actions (opcode 0011, imm 16'h3) on consecutive cycles. Required: 4 issues on consecutive cycles, outstanding=4, 2 entries held in the FIFO. Then pulse eng_done once per cycle; required: each remaining entry issues in the same cycle its eng_done is sampled, and outstanding stays at 4 until the FIFO drains.
- Memory serialisation: 2 ALU actions issued (outstanding=2), then a store (opcode 1001) followed by an addi. Required: FSM enters DRAIN and the store issues only after the 2nd eng_done. The addi does not issue until one edge after the store's eng_done.
- FIFO full: eng_done held low, MAX_OUT reached, 4 more entries written. Required: in_ready=0 and a 5th valid input is not stored. After one eng_done, in_ready=1 one cycle after the pop, and the entries issue in order.
- Underflow: eng_done pulsed with outstanding=0. Required: err_underflow=1 and it stays set; outstanding stays 0. Assert aresetn=0 mid-stream with 3 entries buffered; required: all outputs return to reset values immediately and no buffered entry issues afterward.

Source files
------------

// File: rtl/action_issue_ctrl.sv
// Issue scheduler between lookup and action engines: buffers {action, PHV} pairs,
// tracks in-flight PHVs and serialises load/store actions against all other traffic.
module action_issue_ctrl #(
    parameter int STAGE      = 0,
    parameter int PHV_LEN    = 1024+7+24*8+5*20+256,
    parameter int ACTION_LEN = 25,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_OUT    = 4
) (
    input  logic                  axis_clk,
    input  logic                  aresetn,
    input  logic [ACTION_LEN-1:0] action_in,
    input  logic                  action_in_valid,
    input  logic [PHV_LEN-1:0]    phv_in,
    output logic                  in_ready,
    output logic [ACTION_LEN-1:0] action_out,
    output logic                  action_out_valid,
    output logic [PHV_LEN-1:0]    phv_out,
    input  logic                  eng_done,
    output logic [2:0]            outstanding,
    output logic                  err_underflow
);

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [2:0]      MAX_CNT  = 3'(MAX_OUT);
    localparam logic [3:0]      OP_LOAD  = 4'b1000;
    localparam logic [3:0]      OP_STORE = 4'b1001;

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
        (MAX_OUT < 1) || (MAX_OUT > 7) || (STAGE < 0)) begin : g_bad_cfg
        $error("action_issue_ctrl: unsupported parameterisation");
    end

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    logic [ACTION_LEN-1:0] act_mem [FIFO_DEPTH];
    logic [PHV_LEN-1:0]    phv_mem [FIFO_DEPTH];

    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           cnt_q, cnt_d;
    state_t                state_q, state_d;
    logic [2:0]            out_q, out_d, eff_s;
    logic                  err_q, err_d;
    logic                  valid_q;
    logic [ACTION_LEN-1:0] act_q;
    logic [PHV_LEN-1:0]    phv_q;
    logic                  push_s, issue_s, empty_s, head_mem_s, done_v_s;
    logic [3:0]            head_op_s;

    assign in_ready   = (cnt_q != FULL_CNT);
    assign push_s     = action_in_valid && in_ready;
    assign empty_s    = (cnt_q == {(AW+1){1'b0}});
    assign head_op_s  = act_mem[rd_ptr_q][ACTION_LEN-1 -: 4];
    assign head_mem_s = (head_op_s == OP_LOAD) || (head_op_s == OP_STORE);
    // A done pulse at zero is an underflow and must not count as retiring a PHV
    assign done_v_s   = eng_done && (out_q != 3'd0);
    assign eff_s      = out_q - {2'b00, done_v_s};

    assign action_out       = act_q;
    assign action_out_valid = valid_q;
    assign phv_out          = phv_q;
    assign outstanding      = out_q;
    assign err_underflow    = err_q;

    // Issue decision and next state from the FIFO head and effective in-flight count
    always_comb begin
        issue_s = 1'b0;
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (empty_s) begin
                    issue_s = 1'b0;
                end else if (head_mem_s) begin
                    if (eff_s == 3'd0) begin
                        issue_s = 1'b1;
                        state_d = ST_MEM_WAIT;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (eff_s < MAX_CNT) begin
                    issue_s = 1'b1;
                end else begin
                    issue_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                if ((eff_s == 3'd0) && !empty_s) begin
                    issue_s = 1'b1;
                    state_d = ST_MEM_WAIT;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_MEM_WAIT: begin
                if (eff_s == 3'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_MEM_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Next FIFO occupancy, in-flight count and sticky underflow flag
    always_comb begin
        case ({push_s, issue_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
        if (issue_s && done_v_s) begin
            out_d = out_q;
        end else if (issue_s) begin
            if (out_q == MAX_CNT) begin
                out_d = out_q;
            end else begin
                out_d = out_q + 3'd1;
            end
        end else if (done_v_s) begin
            out_d = out_q - 3'd1;
        end else begin
            out_d = out_q;
        end
        err_d = err_q | (eng_done & ~done_v_s);
    end

    // FSM, pointers, counters and registered issue outputs
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            cnt_q    <= {(AW+1){1'b0}};
            out_q    <= 3'd0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            act_q    <= {ACTION_LEN{1'b0}};
            phv_q    <= {PHV_LEN{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            err_q   <= err_d;
            valid_q <= issue_s;
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (issue_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                act_q    <= act_mem[rd_ptr_q];
                phv_q    <= phv_mem[rd_ptr_q];
            end
        end
    end

    // Buffer storage; reset only needs to clear the pointers
    always_ff @(posedge axis_clk) begin
        if (push_s) begin
            act_mem[wr_ptr_q] <= action_in;
            phv_mem[wr_ptr_q] <= phv_in;
        end
    end

endmodule
